// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory request/response channel
// One transaction outstanding at a time; grants gated by buffer_addr_valid.
module mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      buffer_addr_valid,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mem_req_valid,
  output logic                      mem_req_write,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [DATA_W-1:0]         mem_req_data,
  input  logic                      mem_req_ready,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_W-1:0]         mem_rsp_data,
  output logic                      busy,
  output logic                      spurious_rsp
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e               state_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [PTR_W-1:0]     owner_q;
  logic                 mem_req_valid_q;
  logic                 mem_req_write_q;
  logic [ADDR_W-1:0]    mem_req_addr_q;
  logic [DATA_W-1:0]    mem_req_data_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]    rsp_data_q;
  logic                 spurious_q;

  logic [PTR_W-1:0]     grant_d;
  logic [PTR_W-1:0]     rr_ptr_d;
  logic [PTR_W-1:0]     idx_d;
  logic                 grant_found_d;
  logic                 grant_en_d;
  logic [NUM_REQ-1:0]   grant_onehot_d;
  logic [NUM_REQ-1:0]   owner_onehot_d;
  logic                 sel_write_d;
  logic [ADDR_W-1:0]    sel_addr_d;
  logic [DATA_W-1:0]    sel_data_d;

  // Descending scan so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    grant_found_d = 1'b0;
    grant_d       = '0;
    idx_d         = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_d = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[idx_d]) begin
        grant_found_d = 1'b1;
        grant_d       = idx_d;
      end
    end
  end

  always_comb begin
    sel_write_d = 1'b0;
    sel_addr_d  = '0;
    sel_data_d  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_d == PTR_W'(i)) begin
        sel_write_d = req_write[i];
        sel_addr_d  = req_addr[i*ADDR_W +: ADDR_W];
        sel_data_d  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    grant_onehot_d          = '0;
    grant_onehot_d[grant_d] = 1'b1;
    owner_onehot_d          = '0;
    owner_onehot_d[owner_q] = 1'b1;
  end

  assign grant_en_d = rst_n && (state_q == IDLE) && buffer_addr_valid && grant_found_d;
  assign rr_ptr_d   = (int'(grant_d) == NUM_REQ - 1) ? '0 : grant_d + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rr_ptr_q        <= '0;
      owner_q         <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_write_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_data_q  <= '0;
      rsp_valid_q     <= '0;
      rsp_data_q      <= '0;
      spurious_q      <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (mem_rsp_valid) spurious_q <= 1'b1;
          if (grant_en_d) begin
            mem_req_valid_q <= 1'b1;
            mem_req_write_q <= sel_write_d;
            mem_req_addr_q  <= sel_addr_d;
            mem_req_data_q  <= sel_data_d;
            owner_q         <= grant_d;
            rr_ptr_q        <= rr_ptr_d;
            state_q         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_rsp_valid) spurious_q <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            rsp_data_q  <= mem_rsp_data;
            rsp_valid_q <= owner_onehot_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = grant_en_d ? grant_onehot_d : '0;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_write = mem_req_write_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_data  = mem_req_data_q;
  assign busy          = (state_q == ISSUE) || (state_q == WAIT);
  assign spurious_rsp  = spurious_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a round-robin reference model
module tb_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            buffer_addr_valid;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            mem_req_valid;
  logic            mem_req_write;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_data;
  logic            busy;
  logic            spurious_rsp;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .buffer_addr_valid(buffer_addr_valid),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .spurious_rsp(spurious_rsp)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] v;
    for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction through the memory side and reports what the DUT showed.
  task automatic run_txn(input int stall, input int delay, input logic [DW-1:0] rdata,
                         output logic [N-1:0] g_ready, output logic g_write,
                         output logic [AW-1:0] g_addr, output logic [DW-1:0] g_data,
                         output bit g_stable, output logic [N-1:0] g_rsp,
                         output logic [DW-1:0] g_rsp_data, output bit g_extra);
    int n;
    g_stable = 1'b1; g_extra = 1'b0; g_ready = '0; g_write = 1'b0;
    g_addr = '0; g_data = '0; g_rsp = '0; g_rsp_data = '0; n = 0;
    #1;
    while (req_ready == '0 && n < 50) begin
      step();
      n++;
    end
    if (req_ready == '0) return;
    g_ready = req_ready;
    step();
    if (mem_req_valid !== 1'b1 || busy !== 1'b1) g_stable = 1'b0;
    if (rsp_valid !== '0 || req_ready !== '0) g_extra = 1'b1;
    g_write = mem_req_write; g_addr = mem_req_addr; g_data = mem_req_data;
    mem_req_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      step();
      if (mem_req_valid !== 1'b1 || mem_req_write !== g_write ||
          mem_req_addr !== g_addr || mem_req_data !== g_data) g_stable = 1'b0;
      if (rsp_valid !== '0) g_extra = 1'b1;
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    if (mem_req_valid !== 1'b0 || busy !== 1'b1) g_stable = 1'b0;
    for (int d = 0; d < delay; d++) begin
      step();
      if (rsp_valid !== '0) g_extra = 1'b1;
      if (mem_req_valid !== 1'b0) g_stable = 1'b0;
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rdata;
    step();
    mem_rsp_valid = 1'b0;
    g_rsp = rsp_valid;
    g_rsp_data = rsp_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; buffer_addr_valid = 1'b1; req_valid = 2'b11; req_write = '0;
    req_addr = '0; req_data = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    step(); step();
    checks++;
    if ({req_ready, rsp_valid, mem_req_valid, mem_req_write, busy, spurious_rsp} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0", {req_ready, rsp_valid, mem_req_valid, mem_req_write, busy, spurious_rsp});
    end
    checks++;
    if (mem_req_addr !== '0 || mem_req_data !== '0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_data got addr %h exp 0", mem_req_addr);
    end
    buffer_addr_valid = 1'b0;
    rst_n = 1'b1;
    exp_ptr = 0;
  endtask

  task automatic test_no_buffer();
    int bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (req_ready !== '0 || mem_req_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_buffer_grant got %0d bad cycles exp 0", bad);
    end
    buffer_addr_valid = 1'b1;
  endtask

  task automatic test_basic_read();
    logic [N-1:0] gr, rv; logic gw; logic [AW-1:0] ga; logic [DW-1:0] gd, rd, exp_rd;
    bit st, ex;
    exp_rd = {64{8'hA5}};
    req_valid = 2'b01; req_write = 2'b00; req_addr[0 +: AW] = 64'h40;
    run_txn(0, 5, exp_rd, gr, gw, ga, gd, st, rv, rd, ex);
    req_valid = '0;
    exp_ptr = 1;
    checks++;
    if (gr !== 2'b01) begin errors++; $display("FAIL basic_ready got %b exp 01", gr); end
    checks++;
    if (ga !== 64'h40 || gw !== 1'b0) begin errors++; $display("FAIL basic_cmd got addr %h wr %b exp 40/0", ga, gw); end
    checks++;
    if (rv !== 2'b01) begin errors++; $display("FAIL basic_rsp_valid got %b exp 01", rv); end
    checks++;
    if (rd !== exp_rd) begin errors++; $display("FAIL basic_rsp_data got %h exp %h", rd, exp_rd); end
    checks++;
    if (!st || ex) begin errors++; $display("FAIL basic_protocol got stable %0d extra %0d exp 1/0", st, ex); end
  endtask

  task automatic test_stall_write();
    logic [N-1:0] gr, rv; logic gw; logic [AW-1:0] ga; logic [DW-1:0] gd, rd, exp_d;
    bit st, ex;
    exp_d = DW'(16'h1234);
    req_valid = 2'b10; req_write = 2'b10; req_addr[AW +: AW] = 64'h80; req_data[DW +: DW] = exp_d;
    run_txn(4, 2, rand_wide(), gr, gw, ga, gd, st, rv, rd, ex);
    req_valid = '0;
    exp_ptr = 0;
    checks++;
    if (gr !== 2'b10) begin errors++; $display("FAIL stall_ready got %b exp 10", gr); end
    checks++;
    if (ga !== 64'h80 || gw !== 1'b1 || gd !== exp_d) begin
      errors++; $display("FAIL stall_cmd got addr %h wr %b data %h exp 80/1/1234", ga, gw, gd);
    end
    checks++;
    if (!st || ex) begin errors++; $display("FAIL stall_stable got stable %0d extra %0d exp 1/0", st, ex); end
    checks++;
    if (rv !== 2'b10) begin errors++; $display("FAIL stall_rsp_valid got %b exp 10", rv); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] gr, rv, exp_oh; logic gw; logic [AW-1:0] ga; logic [DW-1:0] gd, rd;
    bit st, ex;
    req_valid = 2'b11; req_write = 2'b00;
    req_addr = {64'h2000, 64'h1000};
    for (int t = 0; t < 6; t++) begin
      exp_oh = N'(1) << (t % 2);
      run_txn(0, 1, rand_wide(), gr, gw, ga, gd, st, rv, rd, ex);
      exp_ptr = ((t % 2) + 1) % N;
      checks++;
      if (gr !== exp_oh || rv !== exp_oh || ga !== (t % 2 == 0 ? 64'h1000 : 64'h2000)) begin
        errors++; $display("FAIL b2b_order[%0d] got ready %b rsp %b addr %h exp %b", t, gr, rv, ga, exp_oh);
      end
      checks++;
      if (!st || ex) begin errors++; $display("FAIL b2b_protocol[%0d] got %0d/%0d exp 1/0", t, st, ex); end
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] gr, rv, v, exp_oh; logic gw; logic [AW-1:0] ga; logic [DW-1:0] gd, rd, rdata;
    bit st, ex;
    int g;
    for (int t = 0; t < 10; t++) begin
      v = N'($urandom_range(1, 3));
      req_valid = v;
      req_write = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_addr[i*AW +: AW] = {$urandom, $urandom};
        req_data[i*DW +: DW] = rand_wide();
      end
      rdata = rand_wide();
      g = rr_pick(exp_ptr, v);
      exp_oh = N'(1) << g;
      run_txn($urandom_range(0, 3), $urandom_range(0, 4), rdata, gr, gw, ga, gd, st, rv, rd, ex);
      exp_ptr = (g + 1) % N;
      checks++;
      if (gr !== exp_oh || rv !== exp_oh) begin
        errors++; $display("FAIL rand_grant[%0d] got ready %b rsp %b exp %b", t, gr, rv, exp_oh);
      end
      checks++;
      if (gw !== req_write[g] || ga !== req_addr[g*AW +: AW] || gd !== req_data[g*DW +: DW]) begin
        errors++; $display("FAIL rand_cmd[%0d] got wr %b addr %h exp wr %b addr %h", t, gw, ga, req_write[g], req_addr[g*AW +: AW]);
      end
      checks++;
      if (rd !== rdata || !st || ex) begin
        errors++; $display("FAIL rand_rsp[%0d] got stable %0d extra %0d data %h exp %h", t, st, ex, rd, rdata);
      end
    end
    req_valid = '0;
    step();
    checks++;
    if (spurious_rsp !== 1'b0) begin errors++; $display("FAIL no_spurious got %b exp 0", spurious_rsp); end
  endtask

  task automatic test_spurious();
    int bad = 0;
    req_valid = '0;
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = rand_wide();
    step();
    mem_rsp_valid = 1'b0;
    checks++;
    if (spurious_rsp !== 1'b1 || busy !== 1'b0 || rsp_valid !== '0) begin
      errors++; $display("FAIL spurious_set got flag %b busy %b rsp %b exp 1/0/00", spurious_rsp, busy, rsp_valid);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      if (spurious_rsp !== 1'b1 || rsp_valid !== '0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL spurious_sticky got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_reset_in_wait();
    logic [N-1:0] gr, rv; logic gw; logic [AW-1:0] ga; logic [DW-1:0] gd, rd;
    bit st, ex;
    int n = 0;
    req_valid = 2'b01;
    #1;
    while (req_ready == '0 && n < 20) begin step(); n++; end
    step();
    req_valid = '0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    checks++;
    if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL wait_reached got busy %b valid %b exp 1/0", busy, mem_req_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, mem_req_valid, mem_req_write, busy, spurious_rsp} !== 8'b0 ||
        mem_req_addr !== '0 || rsp_data !== '0) begin
      errors++; $display("FAIL async_reset got %b addr %h exp 0", {req_ready, rsp_valid, mem_req_valid, mem_req_write, busy, spurious_rsp}, mem_req_addr);
    end
    step();
    rst_n = 1'b1;
    exp_ptr = 0;
    req_valid = 2'b11;
    run_txn(0, 0, rand_wide(), gr, gw, ga, gd, st, rv, rd, ex);
    req_valid = '0;
    checks++;
    if (gr !== 2'b01 || rv !== 2'b01) begin
      errors++; $display("FAIL post_reset_grant got ready %b rsp %b exp 01", gr, rv);
    end
  endtask

  initial begin
    test_reset();
    test_no_buffer();
    test_basic_read();
    test_stall_write();
    test_back_to_back();
    test_random();
    test_spurious();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory request/response channel of the memory block between NUM_REQ requesters, e.g. the cpu and a DMA/accelerator engine.
- Arbitration is round-robin, and only one transaction is outstanding at a time.
- No grant is issued until the memory block reports buffer_addr_valid.
- Sits between the requesters and the memory block inside the AFU top.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- ADDR_W, 64, cache-line address width.
- DATA_W, 512, cache-line data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- buffer_addr_valid  in  1  from memory block; grants are allowed only while high.
- req_valid  in  NUM_REQ  per-requester request valid; held until accepted.
- req_write  in  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed write data, same slicing as req_addr.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_data  out  DATA_W  read data, shared by all requesters; qualified by rsp_valid.
- mem_req_valid  out  1  command valid to memory block.
- mem_req_write  out  1  latched write flag.
- mem_req_addr  out  ADDR_W  latched address.
- mem_req_data  out  DATA_W  latched write data.
- mem_req_ready  in  1  memory block accepts the command.
- mem_rsp_valid  in  1  completion from memory block, for reads and writes.
- mem_rsp_data  in  DATA_W  read data.
- busy  out  1  high in ISSUE or WAIT.
- spurious_rsp  out  1  sticky error flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, rr_ptr=0, owner=0.
  - All registered outputs 0: mem_req_*, rsp_valid, rsp_data, spurious_rsp.
  - req_ready and busy forced 0.
  - Any in-flight transaction is dropped; the memory block is reset by the same rst_n.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... NUM_REQ-1, 0, ... (wraps).
  - req_ready is combinational: req_ready[grant]=1 iff state==IDLE && buffer_addr_valid && |req_valid; all other bits 0.
  - On that edge: latch write/addr/data into mem_req_*, owner<=grant, rr_ptr<=(grant+1) mod NUM_REQ, go to ISSUE.
  - Requesters must not depend on req_ready before asserting req_valid.
- ISSUE:
  - mem_req_valid=1 with latched fields held stable.
  - On the edge where mem_req_valid && mem_req_ready: mem_req_valid<=0, go to WAIT.
- WAIT:
  - On mem_rsp_valid: rsp_data<=mem_rsp_data, rsp_valid<=one-hot(owner), go to IDLE.
  - rsp_valid is high for exactly one cycle, the first IDLE cycle.
  - A new grant may be issued in that same cycle.
  - For writes, rsp_data carries whatever mem_rsp_data holds; requesters ignore it.
- Latency: accept at edge T → mem_req_valid high from T+1. Response at edge R → rsp_valid high in cycle R+1. Minimum accept-to-accept spacing is 3 cycles.
- mem_rsp_valid in IDLE or ISSUE: ignored, and spurious_rsp<=1. spurious_rsp is cleared only by reset.
- buffer_addr_valid deasserting mid-transaction: the in-flight transaction completes normally; no new grant until it reasserts.
- A requester dropping req_valid before accept is legal; it is simply not granted.
- Single requester repeatedly valid: granted every transaction; rr_ptr advances, but the search wraps back to it.
- Simultaneous requests from all requesters: served in rotating order, so each is granted at least once per NUM_REQ grants (no starvation).

Test Plan:
- Reset, then buffer_addr_valid=0 and req_valid=2'b11 for 20 cycles → req_ready stays 0, mem_req_valid stays 0, busy=0.
- buffer_addr_valid=1; req 0 reads addr 0x40; mem_req_ready=1 immediately; mem_rsp_valid 5 cycles later with data 0xA5..A5 → mem_req_addr=0x40, mem_req_write=0, rsp_valid=2'b01 for 1 cycle, rsp_data=0xA5..A5.
- Both requesters continuously valid, 6 transactions → grant order 0,1,0,1,0,1; each rsp_valid pulse matches its owner.
- Req 1 writes addr 0x80 data 0x1234 while mem_req_ready held low 4 cycles → mem_req_valid/addr/data stable across the stall, single accept, rsp_valid=2'b10 after completion.
- mem_rsp_valid pulsed in IDLE → spurious_rsp=1, state stays IDLE, no rsp_valid; flag persists until reset.
- rst_n asserted low while in WAIT → all outputs 0 asynchronously; after release, rr_ptr=0, so requester 0 is granted first when both are valid.
